// File: rtl/regf_write_queue_if.sv
// Bus bundle between writeback/readers, the register-file write queue and the RAM.
// slave = queue side, master = environment side (writeback, RAM, read ports).
interface regf_write_queue_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              i_wr_en_a;
    logic              i_wr_en_b;
    logic [ADDR_W-1:0] i_wr_addr_a;
    logic [ADDR_W-1:0] i_wr_addr_b;
    logic [DATA_W-1:0] i_wr_data_a;
    logic [DATA_W-1:0] i_wr_data_b;
    logic              o_ready;

    logic              o_wen;
    logic [ADDR_W-1:0] o_ram_addr_a;
    logic [ADDR_W-1:0] o_ram_addr_b;
    logic [DATA_W-1:0] o_ram_data_a;
    logic [DATA_W-1:0] o_ram_data_b;
    logic              i_ram_ack;

    logic [ADDR_W-1:0] i_rd_addr_a;
    logic [ADDR_W-1:0] i_rd_addr_b;
    logic [ADDR_W-1:0] i_rd_addr_c;
    logic [ADDR_W-1:0] i_rd_addr_d;
    logic [DATA_W-1:0] i_ram_rd_data_a;
    logic [DATA_W-1:0] i_ram_rd_data_b;
    logic [DATA_W-1:0] i_ram_rd_data_c;
    logic [DATA_W-1:0] i_ram_rd_data_d;
    logic [DATA_W-1:0] o_rd_data_a;
    logic [DATA_W-1:0] o_rd_data_b;
    logic [DATA_W-1:0] o_rd_data_c;
    logic [DATA_W-1:0] o_rd_data_d;

    logic [CNT_W-1:0]  o_count;

    modport slave (
        input  i_wr_en_a, i_wr_en_b, i_wr_addr_a, i_wr_addr_b, i_wr_data_a, i_wr_data_b,
        output o_ready,
        output o_wen, o_ram_addr_a, o_ram_addr_b, o_ram_data_a, o_ram_data_b,
        input  i_ram_ack,
        input  i_rd_addr_a, i_rd_addr_b, i_rd_addr_c, i_rd_addr_d,
        input  i_ram_rd_data_a, i_ram_rd_data_b, i_ram_rd_data_c, i_ram_rd_data_d,
        output o_rd_data_a, o_rd_data_b, o_rd_data_c, o_rd_data_d,
        output o_count
    );

    modport master (
        output i_wr_en_a, i_wr_en_b, i_wr_addr_a, i_wr_addr_b, i_wr_data_a, i_wr_data_b,
        input  o_ready,
        input  o_wen, o_ram_addr_a, o_ram_addr_b, o_ram_data_a, o_ram_data_b,
        output i_ram_ack,
        output i_rd_addr_a, i_rd_addr_b, i_rd_addr_c, i_rd_addr_d,
        output i_ram_rd_data_a, i_ram_rd_data_b, i_ram_rd_data_c, i_ram_rd_data_d,
        input  o_rd_data_a, o_rd_data_b, o_rd_data_c, o_rd_data_d,
        input  o_count
    );
endinterface

// File: rtl/regf_write_queue.sv
// Write-side staging queue for the dual-write register-file RAM: buffers paired writes,
// issues them under ready/ack, and forwards pending data onto the four read ports.
module regf_write_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    regf_write_queue_if.slave   wq
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned NPORTS = 4;

    logic              r_va     [DEPTH];
    logic              r_vb     [DEPTH];
    logic [ADDR_W-1:0] r_addr_a [DEPTH];
    logic [ADDR_W-1:0] r_addr_b [DEPTH];
    logic [DATA_W-1:0] r_data_a [DEPTH];
    logic [DATA_W-1:0] r_data_b [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_ready;
    logic              w_wen;
    logic              w_push;
    logic              w_pop;
    logic              w_new_va;
    logic              w_new_vb;
    logic [ADDR_W-1:0] w_new_addr_a;
    logic [ADDR_W-1:0] w_new_addr_b;
    logic [DATA_W-1:0] w_new_data_a;
    logic [DATA_W-1:0] w_new_data_b;
    logic [PTR_W-1:0]  w_slot    [DEPTH];
    logic [ADDR_W-1:0] w_rd_addr [NPORTS];
    logic [DATA_W-1:0] w_ram_rd  [NPORTS];
    logic [DATA_W-1:0] w_rd_data [NPORTS];

    // Handshake decode uses registered state only, so ack never reaches o_ready.
    assign w_ready = (r_count < CNT_W'(DEPTH));
    assign w_wen   = (r_count != '0);
    assign w_push  = (wq.i_wr_en_a | wq.i_wr_en_b) & w_ready;
    assign w_pop   = w_wen & wq.i_ram_ack;

    // Normalise a request so both RAM lanes always carry a legal, consistent write.
    always_comb begin
        w_new_va     = wq.i_wr_en_a;
        w_new_vb     = wq.i_wr_en_b;
        w_new_addr_a = wq.i_wr_addr_a;
        w_new_addr_b = wq.i_wr_addr_b;
        w_new_data_a = wq.i_wr_data_a;
        w_new_data_b = wq.i_wr_data_b;
        if (wq.i_wr_en_a && wq.i_wr_en_b && (wq.i_wr_addr_a == wq.i_wr_addr_b)) begin
            w_new_va     = 1'b0;
            w_new_addr_a = wq.i_wr_addr_b;
            w_new_data_a = wq.i_wr_data_b;
        end else if (wq.i_wr_en_a && !wq.i_wr_en_b) begin
            w_new_vb     = 1'b1;
            w_new_addr_b = wq.i_wr_addr_a;
            w_new_data_b = wq.i_wr_data_a;
        end else if (!wq.i_wr_en_a && wq.i_wr_en_b) begin
            w_new_va     = 1'b1;
            w_new_addr_a = wq.i_wr_addr_b;
            w_new_data_a = wq.i_wr_data_b;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_va[i]     <= 1'b0;
                r_vb[i]     <= 1'b0;
                r_addr_a[i] <= '0;
                r_addr_b[i] <= '0;
                r_data_a[i] <= '0;
                r_data_b[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_va[r_wr_ptr]     <= w_new_va;
                r_vb[r_wr_ptr]     <= w_new_vb;
                r_addr_a[r_wr_ptr] <= w_new_addr_a;
                r_addr_b[r_wr_ptr] <= w_new_addr_b;
                r_data_a[r_wr_ptr] <= w_new_data_a;
                r_data_b[r_wr_ptr] <= w_new_data_b;
                r_wr_ptr           <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Slot index by age: k = 0 is the head (oldest), k = count-1 the newest.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_slot[k] = r_rd_ptr + PTR_W'(k);
        end
    end

    assign w_rd_addr[0] = wq.i_rd_addr_a;
    assign w_rd_addr[1] = wq.i_rd_addr_b;
    assign w_rd_addr[2] = wq.i_rd_addr_c;
    assign w_rd_addr[3] = wq.i_rd_addr_d;
    assign w_ram_rd[0]  = wq.i_ram_rd_data_a;
    assign w_ram_rd[1]  = wq.i_ram_rd_data_b;
    assign w_ram_rd[2]  = wq.i_ram_rd_data_c;
    assign w_ram_rd[3]  = wq.i_ram_rd_data_d;

    // Oldest-to-newest sweep where later hits overwrite: newest entry wins, B over A.
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            w_rd_data[p] = w_ram_rd[p];
            for (int k = 0; k < DEPTH; k++) begin
                if (CNT_W'(k) < r_count) begin
                    if (r_va[w_slot[k]] && (r_addr_a[w_slot[k]] == w_rd_addr[p])) begin
                        w_rd_data[p] = r_data_a[w_slot[k]];
                    end
                    if (r_vb[w_slot[k]] && (r_addr_b[w_slot[k]] == w_rd_addr[p])) begin
                        w_rd_data[p] = r_data_b[w_slot[k]];
                    end
                end
            end
        end
    end

    assign wq.o_ready      = w_ready;
    assign wq.o_wen        = w_wen;
    assign wq.o_count      = r_count;
    assign wq.o_ram_addr_a = r_addr_a[r_rd_ptr];
    assign wq.o_ram_addr_b = r_addr_b[r_rd_ptr];
    assign wq.o_ram_data_a = r_data_a[r_rd_ptr];
    assign wq.o_ram_data_b = r_data_b[r_rd_ptr];
    assign wq.o_rd_data_a  = w_rd_data[0];
    assign wq.o_rd_data_b  = w_rd_data[1];
    assign wq.o_rd_data_c  = w_rd_data[2];
    assign wq.o_rd_data_d  = w_rd_data[3];
endmodule

// File: tb/tb_regf_write_queue.sv
// Directed bench for regf_write_queue: merge, bypass, full/refuse, wrap order and async reset.
module tb_regf_write_queue;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    regf_write_queue_if #(.DEPTH(4), .ADDR_W(6), .DATA_W(32)) wq ();

    regf_write_queue #(.DEPTH(4), .ADDR_W(6), .DATA_W(32)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .wq      (wq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        wq.i_wr_en_a = 1'b0;  wq.i_wr_en_b = 1'b0;
        wq.i_wr_addr_a = '0;  wq.i_wr_addr_b = '0;
        wq.i_wr_data_a = '0;  wq.i_wr_data_b = '0;
        wq.i_ram_ack = 1'b0;
        wq.i_rd_addr_a = '0;  wq.i_rd_addr_b = '0;
        wq.i_rd_addr_c = '0;  wq.i_rd_addr_d = '0;
        wq.i_ram_rd_data_a = '0;  wq.i_ram_rd_data_b = '0;
        wq.i_ram_rd_data_c = '0;  wq.i_ram_rd_data_d = '0;
    endtask

    task automatic push(input logic ea, input logic [5:0] aa, input logic [31:0] da,
                        input logic eb, input logic [5:0] ab, input logic [31:0] db);
        wq.i_wr_en_a = ea;  wq.i_wr_addr_a = aa;  wq.i_wr_data_a = da;
        wq.i_wr_en_b = eb;  wq.i_wr_addr_b = ab;  wq.i_wr_data_b = db;
    endtask

    task automatic no_push();
        wq.i_wr_en_a = 1'b0;
        wq.i_wr_en_b = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        clear_in();
        tick();
        tick();
        chk("rst_count", 64'(wq.o_count), 64'd0);
        chk("rst_wen", 64'(wq.o_wen), 64'd0);
        chk("rst_ready", 64'(wq.o_ready), 64'd1);
        chk("rst_addr_a", 64'(wq.o_ram_addr_a), 64'd0);
        chk("rst_data_b", 64'(wq.o_ram_data_b), 64'd0);
        rst = 1'b0;
        tick();

        // Single A write, then ack; then a stray ack on an empty queue.
        push(1'b1, 6'd5, 32'h1234_5678, 1'b0, 6'd0, 32'h0);
        tick();
        no_push();
        chk("t1_wen", 64'(wq.o_wen), 64'd1);
        chk("t1_addr_a", 64'(wq.o_ram_addr_a), 64'd5);
        chk("t1_addr_b", 64'(wq.o_ram_addr_b), 64'd5);
        chk("t1_data_a", 64'(wq.o_ram_data_a), 64'h1234_5678);
        chk("t1_data_b", 64'(wq.o_ram_data_b), 64'h1234_5678);
        chk("t1_count", 64'(wq.o_count), 64'd1);
        wq.i_ram_ack = 1'b1;
        tick();
        chk("t1_pop_count", 64'(wq.o_count), 64'd0);
        chk("t1_pop_wen", 64'(wq.o_wen), 64'd0);
        tick();
        wq.i_ram_ack = 1'b0;
        chk("t1_empty_ack", 64'(wq.o_count), 64'd0);

        // Same-address pair: B wins and both lanes carry B; not bypassed in the push cycle.
        wq.i_rd_addr_a = 6'd3;
        wq.i_ram_rd_data_a = 32'h55;
        push(1'b1, 6'd3, 32'h11, 1'b1, 6'd3, 32'h22);
        #1;
        chk("t2_no_same_cycle_byp", 64'(wq.o_rd_data_a), 64'h55);
        tick();
        no_push();
        wq.i_ram_rd_data_a = 32'h0;
        #1;
        chk("t2_byp", 64'(wq.o_rd_data_a), 64'h22);
        chk("t2_addr_a", 64'(wq.o_ram_addr_a), 64'd3);
        chk("t2_addr_b", 64'(wq.o_ram_addr_b), 64'd3);
        chk("t2_data_a", 64'(wq.o_ram_data_a), 64'h22);
        chk("t2_data_b", 64'(wq.o_ram_data_b), 64'h22);
        wq.i_ram_ack = 1'b1;
        tick();
        wq.i_ram_ack = 1'b0;
        chk("t2_count", 64'(wq.o_count), 64'd0);

        // Two writes to r7; newest wins on all ports until both are committed.
        push(1'b1, 6'd7, 32'hA, 1'b0, 6'd0, 32'h0);
        tick();
        push(1'b0, 6'd0, 32'h0, 1'b1, 6'd7, 32'hB);
        tick();
        no_push();
        wq.i_rd_addr_a = 6'd7;  wq.i_rd_addr_b = 6'd7;
        wq.i_rd_addr_c = 6'd7;  wq.i_rd_addr_d = 6'd7;
        wq.i_ram_rd_data_a = 32'hDEAD;  wq.i_ram_rd_data_b = 32'hDEAD;
        wq.i_ram_rd_data_c = 32'hDEAD;  wq.i_ram_rd_data_d = 32'hDEAD;
        #1;
        chk("t3_count", 64'(wq.o_count), 64'd2);
        chk("t3_rd_a", 64'(wq.o_rd_data_a), 64'hB);
        chk("t3_rd_b", 64'(wq.o_rd_data_b), 64'hB);
        chk("t3_rd_c", 64'(wq.o_rd_data_c), 64'hB);
        chk("t3_rd_d", 64'(wq.o_rd_data_d), 64'hB);
        wq.i_ram_ack = 1'b1;
        tick();
        wq.i_ram_ack = 1'b0;
        chk("t3_ack1_rd", 64'(wq.o_rd_data_a), 64'hB);
        chk("t3_ack1_head_data_a", 64'(wq.o_ram_data_a), 64'hB);
        wq.i_ram_ack = 1'b1;
        tick();
        wq.i_ram_ack = 1'b0;
        chk("t3_ack2_rd", 64'(wq.o_rd_data_c), 64'hDEAD);
        clear_in();

        // Fill all four entries, then push+ack together while full.
        push(1'b1, 6'd1, 32'h101, 1'b1, 6'd2, 32'h202);
        tick();
        push(1'b1, 6'd10, 32'h10, 1'b0, 6'd0, 32'h0);
        tick();
        push(1'b0, 6'd0, 32'h0, 1'b1, 6'd11, 32'h11);
        tick();
        push(1'b1, 6'd12, 32'h12, 1'b0, 6'd0, 32'h0);
        tick();
        no_push();
        wq.i_rd_addr_a = 6'd1;   wq.i_rd_addr_b = 6'd2;
        wq.i_rd_addr_c = 6'd11;  wq.i_rd_addr_d = 6'd12;
        #1;
        chk("t4_ready_full", 64'(wq.o_ready), 64'd0);
        chk("t4_count_full", 64'(wq.o_count), 64'd4);
        chk("t4_byp_a_lane", 64'(wq.o_rd_data_a), 64'h101);
        chk("t4_byp_b_lane", 64'(wq.o_rd_data_b), 64'h202);
        chk("t4_byp_bonly", 64'(wq.o_rd_data_c), 64'h11);
        chk("t4_byp_aonly", 64'(wq.o_rd_data_d), 64'h12);
        chk("t4_head_addr_a", 64'(wq.o_ram_addr_a), 64'd1);
        chk("t4_head_addr_b", 64'(wq.o_ram_addr_b), 64'd2);
        push(1'b1, 6'd20, 32'h20, 1'b0, 6'd0, 32'h0);
        wq.i_ram_ack = 1'b1;
        #1;
        chk("t4_ready_during", 64'(wq.o_ready), 64'd0);
        tick();
        no_push();
        wq.i_ram_ack = 1'b0;
        wq.i_rd_addr_a = 6'd20;  wq.i_ram_rd_data_a = 32'h5;
        wq.i_rd_addr_b = 6'd1;   wq.i_ram_rd_data_b = 32'h9;
        #1;
        chk("t4_count_after", 64'(wq.o_count), 64'd3);
        chk("t4_ready_after", 64'(wq.o_ready), 64'd1);
        chk("t4_refused_not_queued", 64'(wq.o_rd_data_a), 64'h5);
        chk("t4_popped_excluded", 64'(wq.o_rd_data_b), 64'h9);
        chk("t4_head2_addr_a", 64'(wq.o_ram_addr_a), 64'd10);
        chk("t4_head2_addr_b", 64'(wq.o_ram_addr_b), 64'd10);
        wq.i_ram_ack = 1'b1;
        tick();
        chk("t4_head3_addr_b", 64'(wq.o_ram_addr_b), 64'd11);
        chk("t4_head3_data_a", 64'(wq.o_ram_data_a), 64'h11);
        tick();
        chk("t4_head4_addr_a", 64'(wq.o_ram_addr_a), 64'd12);
        chk("t4_head4_count", 64'(wq.o_count), 64'd1);
        tick();
        wq.i_ram_ack = 1'b0;
        chk("t4_drained", 64'(wq.o_count), 64'd0);
        clear_in();

        // Ten pipelined push/ack pairs; each cycle the head must be the latest push.
        for (int i = 0; i < 10; i++) begin
            push(1'b1, 6'(i + 30), 32'h1000 + 32'(i), 1'b0, 6'd0, 32'h0);
            wq.i_ram_ack = (i > 0);
            tick();
            chk($sformatf("t5_head_addr_%0d", i), 64'(wq.o_ram_addr_b), 64'(i + 30));
            chk($sformatf("t5_head_data_%0d", i), 64'(wq.o_ram_data_a), 64'h1000 + 64'(i));
            chk($sformatf("t5_count_%0d", i), 64'(wq.o_count), 64'd1);
        end
        no_push();
        wq.i_ram_ack = 1'b1;
        tick();
        wq.i_ram_ack = 1'b0;
        chk("t5_final_count", 64'(wq.o_count), 64'd0);

        // Asynchronous reset with three entries queued.
        push(1'b1, 6'd40, 32'h40, 1'b0, 6'd0, 32'h0);
        tick();
        push(1'b1, 6'd41, 32'h41, 1'b0, 6'd0, 32'h0);
        tick();
        push(1'b1, 6'd42, 32'h42, 1'b0, 6'd0, 32'h0);
        tick();
        no_push();
        chk("t6_pre_count", 64'(wq.o_count), 64'd3);
        #2;
        rst = 1'b1;
        wq.i_rd_addr_a = 6'd41;  wq.i_ram_rd_data_a = 32'h77;
        #1;
        chk("t6_async_wen", 64'(wq.o_wen), 64'd0);
        chk("t6_async_count", 64'(wq.o_count), 64'd0);
        chk("t6_raw_read", 64'(wq.o_rd_data_a), 64'h77);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_post_wen", 64'(wq.o_wen), 64'd0);
        chk("t6_post_ready", 64'(wq.o_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
